// File: rtl/instr_fetch_unit.sv
// RV64 fetch stage: PC, one-outstanding imem request/grant/response, instruction register.
// Latency: grant N, rvalid N+1, instr_valid N+2. Backpressure: stall holds the instruction register.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps into FAULT instead of being forced aligned.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] pc_out,
  output logic        misalign_trap
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {FETCH, WAIT, HOLD, DROP, FAULT} state_t;
`else
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;
`endif

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        vld_q, vld_d;
  logic        trap_q, trap_d;
  logic        drop_fault_q, drop_fault_d;
  logic        in_flight;
  logic        misaligned;
  logic [63:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |redirect_target[1:0];
  assign target     = redirect_target;
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^redirect_target[1:0];
  assign misaligned        = 1'b0;
  assign target            = {redirect_target[63:2], 2'b00};
`endif

  // A response is still owed if a grant happens now or an earlier grant has not been answered.
  assign in_flight = (state_q == FETCH && imem_gnt) ||
                     ((state_q == WAIT || state_q == DROP) && !imem_rvalid);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    vld_d        = vld_q;
    trap_d       = trap_q;
    drop_fault_d = drop_fault_q;
    if (redirect) begin
      pc_d    = target;
      vld_d   = 1'b0;
      instr_d = NOP_WORD;
      trap_d  = misaligned;
`ifdef FETCH_MISALIGN_TRAP_EN
      drop_fault_d = misaligned;
      if (in_flight)       state_d = DROP;
      else if (misaligned) state_d = FAULT;
      else                 state_d = FETCH;
`else
      drop_fault_d = 1'b0;
      state_d      = in_flight ? DROP : FETCH;
`endif
    end else begin
      case (state_q)
        FETCH: if (imem_gnt) state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            vld_d   = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_d    = pc_q + 64'd4;
            vld_d   = 1'b0;
            instr_d = NOP_WORD;
            state_d = FETCH;
          end
        end
        DROP: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (imem_rvalid) state_d = drop_fault_q ? FAULT : FETCH;
`else
          if (imem_rvalid) state_d = FETCH;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_WORD;
      vld_q        <= 1'b0;
      trap_q       <= 1'b0;
      drop_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      vld_q        <= vld_d;
      trap_q       <= trap_d;
      drop_fault_q <= drop_fault_d;
    end
  end

  // Request is suppressed while reset is asserted so nothing is issued before release.
  assign imem_req      = reset && (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign pc_out        = pc_q;
  assign instruction   = instr_q;
  assign instr_valid   = vld_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expected {pc, word} pairs are queued at response time and
// checked by a monitor on each new instr_valid.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc_out;
  logic        misalign_trap;

  localparam logic [31:0] NOP = 32'h00000013;

  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];
  logic prev_vld = 1'b0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc_out(pc_out), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising instr_valid must match the next queued fetch.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (instr_valid && !prev_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got %h at pc %h expected none", instruction, pc_out);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          chk("mon_instr", {32'h0, instruction}, {32'h0, e[31:0]});
          chk("mon_pc", pc_out, e[95:32]);
        end
      end
      if (instr_valid && instruction == 32'hDEADBEEF) begin
        checks++;
        errors++;
        $display("FAIL stale_data: got %h expected discarded", instruction);
      end
    end
    prev_vld = instr_valid;
  end

  task automatic fetch_one(input logic [63:0] addr, input logic [31:0] data, input int gnt_delay);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 64'(imem_req), 64'd1);
    chk("fetch_addr", imem_addr, addr);
    for (int i = 0; i < gnt_delay; i++) begin
      tick();
      chk("req_hold", 64'(imem_req), 64'd1);
      chk("addr_hold", imem_addr, addr);
      chk("no_vld_ungranted", 64'(instr_valid), 64'd0);
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("req_low_in_wait", 64'(imem_req), 64'd0);
    exp_q.push_back({addr, data});
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    chk("vld_two_after_gnt", 64'(instr_valid), 64'd1);
  endtask

  task automatic consume();
    stall = 1'b0;
    tick();
    stall = 1'b1;
  endtask

  task automatic do_redirect(input logic [63:0] tgt);
    redirect        = 1'b1;
    redirect_target = tgt;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_instr;
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    stall = 1'b1; redirect = 1'b0; redirect_target = 64'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_instr", {32'h0, instruction}, {32'h0, NOP});
    chk("rst_vld", 64'(instr_valid), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_trap", 64'(misalign_trap), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // First fetch, immediate grant, then held under stall.
    fetch_one(64'h0, 32'h00A00093, 0);
    held_instr = instruction;
    chk("first_instr", {32'h0, held_instr}, 64'h00A00093);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", {32'h0, instruction}, {32'h0, held_instr});
      chk("stall_pc", pc_out, 64'h0);
      chk("stall_vld", 64'(instr_valid), 64'd1);
      chk("stall_no_req", 64'(imem_req), 64'd0);
    end
    consume();
    chk("next_addr", imem_addr, 64'h4);
    chk("consume_vld", 64'(instr_valid), 64'd0);
    chk("consume_nop", {32'h0, instruction}, {32'h0, NOP});

    // Grant withheld three cycles.
    fetch_one(64'h4, 32'h00100113, 3);
    consume();

    // Redirect while waiting for the response; stale word must be dropped.
    chk("pre_redir_addr", imem_addr, 64'h8);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    do_redirect(64'h100);
    chk("drop_no_req", 64'(imem_req), 64'd0);
    chk("drop_pc", pc_out, 64'h100);
    tick();
    chk("drop_no_req2", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("after_drop_req", 64'(imem_req), 64'd1);
    chk("after_drop_addr", imem_addr, 64'h100);
    chk("after_drop_vld", 64'(instr_valid), 64'd0);
    fetch_one(64'h100, 32'h00200193, 1);
    consume();

    // PC wrap at the top of the address space.
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_redir_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h00000073, 0);
    consume();
    chk("wrap_addr", imem_addr, 64'h0);

    // Redirect in HOLD wins over stall.
    fetch_one(64'h0, 32'h00300213, 0);
    do_redirect(64'h300);
    chk("hold_redir_vld", 64'(instr_valid), 64'd0);
    chk("hold_redir_nop", {32'h0, instruction}, {32'h0, NOP});
    chk("hold_redir_addr", imem_addr, 64'h300);

    // Misaligned redirect target.
    do_redirect(64'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_set", 64'(misalign_trap), 64'd1);
    chk("trap_pc", pc_out, 64'h102);
    for (int i = 0; i < 3; i++) begin
      chk("trap_no_req", 64'(imem_req), 64'd0);
      tick();
    end
    do_redirect(64'h200);
    chk("trap_clear", 64'(misalign_trap), 64'd0);
    chk("trap_exit_addr", imem_addr, 64'h200);
    fetch_one(64'h200, 32'h00400293, 0);
`else
    chk("align_trap", 64'(misalign_trap), 64'd0);
    chk("align_addr", imem_addr, 64'h100);
    fetch_one(64'h100, 32'h00400293, 0);
`endif
    consume();
    repeat (2) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
